// File: rtl/vm_pkg.sv
// Shared types and address layout for the video-memory fetcher.
package vm_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_REQ     = 2'd1,
    BUS_CAPTURE = 2'd2,
    BUS_GAP     = 2'd3
  } bus_state_t;

  typedef enum logic {
    KIND_LINE  = 1'b0,
    KIND_HISTO = 1'b1
  } kind_t;

  localparam int WORDS_DEFAULT = 256;

  localparam int ADDR_W        = 10;
  localparam int ADDR_KIND_BIT = 9;
  localparam int ADDR_BANK_BIT = 8;
  localparam int ADDR_WORD_MSB = 7;

  // Builds the request address from memory select, bank and word index.
  function automatic logic [ADDR_W-1:0] make_addr(input kind_t kind, input logic bank,
                                                  input logic [ADDR_WORD_MSB:0] word);
    logic [ADDR_W-1:0] a;
    a                   = '0;
    a[ADDR_KIND_BIT]    = kind;
    a[ADDR_BANK_BIT]    = bank;
    a[ADDR_WORD_MSB:0]  = word;
    return a;
  endfunction

endpackage

// File: rtl/vm_read_master.sv
// Single-word read handshake towards the video memory plus the output
// register that presents each fetched word to the downstream consumer.
module vm_read_master
  import vm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_last,
  input  logic              i_ack,
  input  logic [63:0]       i_rdata,
  input  logic              i_ready,
  output logic              o_bus_enable,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_idle,
  output logic              o_word_done,
  output logic [63:0]       o_data,
  output logic              o_valid,
  output logic              o_kind,
  output logic              o_last
);

  bus_state_t  r_state;
  bus_state_t  w_next;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_kind;
  logic        r_last;

  // State register; reset drops any request that is in flight.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= BUS_IDLE;
    else      r_state <= w_next;
  end

  // Next state and strobes; CAPTURE and GAP keep the enable low so the
  // edge-sensitive responder always sees a fresh rising edge per word.
  always_comb begin
    w_next       = r_state;
    o_bus_enable = 1'b0;
    o_word_done  = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (i_start) w_next = BUS_REQ;
      end
      BUS_REQ: begin
        o_bus_enable = 1'b1;
        if (i_ack) begin
          o_word_done = 1'b1;
          w_next      = BUS_CAPTURE;
        end
      end
      BUS_CAPTURE: begin
        w_next = r_last ? BUS_IDLE : BUS_GAP;
      end
      BUS_GAP: begin
        if (!r_valid || i_ready) w_next = BUS_REQ;
      end
      default: w_next = BUS_IDLE;
    endcase
  end

  assign o_address = o_bus_enable ? i_addr : '0;
  assign o_idle    = (r_state == BUS_IDLE);

  // Output register: loaded in the ack cycle, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_kind  <= 1'b0;
      r_last  <= 1'b0;
    end else if (o_word_done) begin
      r_data  <= i_rdata;
      r_kind  <= i_addr[ADDR_KIND_BIT];
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_kind  = r_kind;
  assign o_last  = r_last;

endmodule

// File: rtl/vm_fetcher.sv
// Watches the capture block's bank toggles and streams each completed
// line or histogram bank out of video memory, one word per handshake.
module vm_fetcher
  import vm_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] vm_address,
  output logic              vm_bus_enable,
  output logic              vm_rw,
  input  logic              vm_acknowledge,
  input  logic [63:0]       vm_read_data,
  input  logic              status_which_line,
  input  logic              status_which_histo,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

  logic              r_line_q;
  logic              r_histo_q;
  logic              r_pend_line;
  logic              r_pend_histo;
  logic              r_bank_line;
  logic              r_bank_histo;
  kind_t             r_act_kind;
  logic              r_act_bank;
  logic [7:0]        r_word;
  logic              r_busy;
  logic              r_overrun;

  logic              w_line_evt;
  logic              w_histo_evt;
  logic              w_idle;
  logic              w_word_done;
  logic              w_start;
  kind_t             w_start_kind;
  logic              w_start_bank;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  assign w_line_evt   = status_which_line ^ r_line_q;
  assign w_histo_evt  = status_which_histo ^ r_histo_q;
  assign w_start_kind = r_pend_line ? KIND_LINE : KIND_HISTO;
  assign w_start_bank = r_pend_line ? r_bank_line : r_bank_histo;
  assign w_start      = w_idle && (r_pend_line || r_pend_histo) && (!out_valid || out_ready);
  assign w_last       = (r_word == LAST_WORD);
  assign w_addr       = make_addr(r_act_kind, r_act_bank, r_word);

  // Toggle copies track the inputs even in reset so release is event-free.
  always_ff @(posedge clk) begin
    r_line_q  <= status_which_line;
    r_histo_q <= status_which_histo;
  end

  // Pending flags and completed-bank latches; a new event always wins so the
  // newest bank is the one fetched next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_line  <= 1'b0;
      r_pend_histo <= 1'b0;
      r_bank_line  <= 1'b0;
      r_bank_histo <= 1'b0;
    end else begin
      if (w_line_evt) begin
        r_pend_line <= 1'b1;
        r_bank_line <= r_line_q;
      end else if (w_start && (w_start_kind == KIND_LINE)) begin
        r_pend_line <= 1'b0;
      end
      if (w_histo_evt) begin
        r_pend_histo <= 1'b1;
        r_bank_histo <= r_histo_q;
      end else if (w_start && (w_start_kind == KIND_HISTO)) begin
        r_pend_histo <= 1'b0;
      end
    end
  end

  // Transfer sequencer: latches kind/bank for the whole transfer and counts words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_act_kind <= KIND_LINE;
      r_act_bank <= 1'b0;
      r_word     <= '0;
      r_busy     <= 1'b0;
    end else if (w_start) begin
      r_act_kind <= w_start_kind;
      r_act_bank <= w_start_bank;
      r_word     <= '0;
      r_busy     <= 1'b1;
    end else if (w_word_done) begin
      r_word <= r_word + 8'd1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  // Sticky overrun: an event arrived for a bank still waiting or being fetched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if ((w_line_evt && (r_pend_line || (r_busy && (r_act_kind == KIND_LINE)))) ||
                 (w_histo_evt && (r_pend_histo || (r_busy && (r_act_kind == KIND_HISTO))))) begin
      r_overrun <= 1'b1;
    end
  end

  vm_read_master u_master (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .i_addr       (w_addr),
    .i_last       (w_last),
    .i_ack        (vm_acknowledge),
    .i_rdata      (vm_read_data),
    .i_ready      (out_ready),
    .o_bus_enable (vm_bus_enable),
    .o_address    (vm_address),
    .o_idle       (w_idle),
    .o_word_done  (w_word_done),
    .o_data       (out_data),
    .o_valid      (out_valid),
    .o_kind       (out_kind),
    .o_last       (out_last)
  );

  assign vm_rw   = vm_bus_enable;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_vm_fetcher.sv
// Directed bench for vm_fetcher: an edge-sensitive memory responder, an
// output monitor fed from expected-word queues, and a scripted sequence.
module tb_vm_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  vm_address;
  logic        vm_bus_enable;
  logic        vm_rw;
  logic        vm_acknowledge = 1'b0;
  logic [63:0] vm_read_data = '0;
  logic        status_which_line;
  logic        status_which_histo;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          rxCount = 0;

  logic [9:0]  expAddrQ[$];
  logic [65:0] expWordQ[$];

  always #5 clk = ~clk;

  vm_fetcher #(.WORDS(256)) dut (
    .clk                (clk),
    .rst                (rst),
    .vm_address         (vm_address),
    .vm_bus_enable      (vm_bus_enable),
    .vm_rw              (vm_rw),
    .vm_acknowledge     (vm_acknowledge),
    .vm_read_data       (vm_read_data),
    .status_which_line  (status_which_line),
    .status_which_histo (status_which_histo),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_kind           (out_kind),
    .out_last           (out_last),
    .busy               (busy),
    .overrun            (overrun)
  );

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Memory contents as seen by the responder: a fixed function of the address.
  function automatic logic [63:0] respData(input logic [9:0] a);
    logic [31:0] m;
    m = {22'b0, a} * 32'h9E3779B1;
    return {a, 6'h2A, 16'hC0DE ^ {6'b0, a}, m};
  endfunction

  // Queues the 256 requests and output words one bank transfer should produce.
  task automatic pushTransfer(input logic kind, input logic bank);
    for (int w = 0; w < 256; w++) begin
      logic [9:0] a;
      a = {kind, bank, 8'(w)};
      expAddrQ.push_back(a);
      expWordQ.push_back({kind, (w == 255), respData(a)});
    end
  endtask

  // Drives the status toggles and out_ready just after a rising edge.
  task automatic applyStimulus(input logic line, input logic histo, input logic ready);
    @(posedge clk);
    #1;
    status_which_line  = line;
    status_which_histo = histo;
    out_ready          = ready;
  endtask

  // Waits until every queued word has been delivered and the fetcher is quiet.
  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!(expWordQ.size() == 0 && !busy && !out_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "Remaining"}, 64'(expWordQ.size()), 64'd0);
    checkOutput({tag, "ReqRemaining"}, 64'(expAddrQ.size()), 64'd0);
    checkOutput({tag, "BusyClear"}, 64'(busy), 64'd0);
  endtask

  // Waits until the monitor has seen a given number of delivered words.
  task automatic waitWords(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (rxCount < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    checkOutput(tag, 64'(rxCount >= target), 64'd1);
  endtask

  // Responder: arms on each rising edge of the enable, acks one cycle (or two
  // for odd addresses) later, and checks each request against the queue.
  logic       prevEn = 1'b0;
  logic       armed = 1'b0;
  int         delay = 0;
  logic [9:0] armAddr = '0;
  always @(negedge clk) begin
    if (!vm_bus_enable) armed = 1'b0;
    if (vm_acknowledge) begin
      vm_acknowledge = 1'b0;
    end else if (armed) begin
      if (delay == 0) begin
        checkOutput("addrStable", 64'(vm_address), 64'(armAddr));
        vm_acknowledge = 1'b1;
        vm_read_data   = respData(vm_address);
        armed          = 1'b0;
      end else begin
        delay--;
      end
    end
    if (vm_bus_enable && !prevEn) begin
      armed   = 1'b1;
      armAddr = vm_address;
      delay   = vm_address[0] ? 1 : 0;
      checkOutput("reqRw", 64'(vm_rw), 64'd1);
      if (expAddrQ.size() == 0) checkOutput("reqQueued", 64'(expAddrQ.size()), 64'd1);
      else                      checkOutput("reqAddr", 64'(vm_address), 64'(expAddrQ.pop_front()));
    end
    prevEn = vm_bus_enable;
  end

  // Monitor: checks each delivered word in order and that stalled words hold.
  logic        prevHeld = 1'b0;
  logic [63:0] heldData = '0;
  logic [65:0] expWord;
  always @(negedge clk) begin
    if (prevHeld) begin
      checkOutput("holdValid", 64'(out_valid), 64'd1);
      checkOutput("holdData", out_data, heldData);
    end
    prevHeld = rst && out_valid && !out_ready;
    heldData = out_data;
    if (rst && out_valid && out_ready) begin
      rxCount++;
      if (expWordQ.size() == 0) begin
        checkOutput("wordQueued", 64'(expWordQ.size()), 64'd1);
      end else begin
        expWord = expWordQ.pop_front();
        checkOutput("outData", out_data, expWord[63:0]);
        checkOutput("outKind", 64'(out_kind), 64'(expWord[65]));
        checkOutput("outLast", 64'(out_last), 64'(expWord[64]));
      end
    end
  end

  // Safety net in case a wait ever escapes its bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scripted sequence of directed scenarios.
  initial begin
    int n;
    int enSeen;
    rst                = 1'b0;
    status_which_line  = 1'b0;
    status_which_histo = 1'b1;
    out_ready          = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstEnable", 64'(vm_bus_enable), 64'd0);
    checkOutput("rstRw", 64'(vm_rw), 64'd0);
    checkOutput("rstAddress", 64'(vm_address), 64'd0);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstData", out_data, 64'd0);
    checkOutput("rstKind", 64'(out_kind), 64'd0);
    checkOutput("rstLast", 64'(out_last), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstOverrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    enSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (vm_bus_enable || busy) enSeen++;
    end
    checkOutput("releaseQuiet", 64'(enSeen), 64'd0);

    // Line 0->1: bank 0 of line memory, 0x000..0x0FF
    $display("[TB] line transfer bank 0");
    pushTransfer(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitDone("lineA", 4000);
    checkOutput("lineAOverrun", 64'(overrun), 64'd0);

    // Histo 1->0: bank 1 of histogram memory, 0x300..0x3FF
    $display("[TB] histo transfer bank 1");
    pushTransfer(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDone("histoB", 4000);
    checkOutput("histoBOverrun", 64'(overrun), 64'd0);

    // Both toggles together: line bank 1 completes before histo bank 0
    $display("[TB] simultaneous line and histo");
    pushTransfer(1'b0, 1'b1);
    pushTransfer(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitDone("bothC", 8000);
    checkOutput("bothCOverrun", 64'(overrun), 64'd0);

    // Second line toggle at word 100 of a line transfer
    $display("[TB] overrun during line transfer");
    pushTransfer(1'b0, 1'b0);
    n = rxCount;
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitWords("reachWord100", n + 100, 2000);
    checkOutput("preOverrun", 64'(overrun), 64'd0);
    pushTransfer(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("overrunSet", 64'(overrun), 64'd1);
    checkOutput("overrunBusy", 64'(busy), 64'd1);
    waitDone("overrunE", 8000);
    checkOutput("overrunSticky", 64'(overrun), 64'd1);

    // Consumer stall for 20 cycles mid-transfer
    $display("[TB] consumer stall");
    pushTransfer(1'b0, 1'b0);
    n = rxCount;
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitWords("reachWord50", n + 50, 2000);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 5) checkOutput("stallEnable", 64'(vm_bus_enable), 64'd0);
    end
    checkOutput("stallValid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitDone("stallD", 4000);

    // Reset while a request is outstanding
    $display("[TB] reset during request");
    expAddrQ.push_back(10'h300);
    applyStimulus(1'b1, 1'b0, 1'b1);
    n = 0;
    while (!vm_bus_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqSeen", 64'(vm_bus_enable), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortEnable", 64'(vm_bus_enable), 64'd0);
    checkOutput("abortRw", 64'(vm_rw), 64'd0);
    checkOutput("abortAddress", 64'(vm_address), 64'd0);
    checkOutput("abortValid", 64'(out_valid), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortOverrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    enSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (vm_bus_enable || out_valid || busy) enSeen++;
    end
    checkOutput("abortQuiet", 64'(enSeen), 64'd0);
    checkOutput("abortReqQueue", 64'(expAddrQ.size()), 64'd0);
    checkOutput("abortWordQueue", 64'(expWordQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/vm_fetcher.md
VM_FETCHER -- requirements
Module: vm_fetcher

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: vm_address  out  10  [9]=memory select (0 line, 1 histo), [8]=bank, [7:0]=word index.
REQ-004 SHALL have ports: vm_bus_enable  out  1  request strobe; vm_rw  out  1  read select, equals vm_bus_enable.
REQ-005 SHALL have ports: vm_acknowledge  in  1  one-cycle ack; vm_read_data  in  64  valid in the ack cycle.
REQ-006 SHALL have ports: status_which_line  in  1  and status_which_histo  in  1  bank toggles from the capture block.
REQ-007 SHALL have ports: out_data  out  64; out_valid  out  1; out_ready  in  1; out_kind  out  1 (0 line, 1 histo); out_last  out  1 (word 255).
REQ-008 SHALL have ports: busy  out  1  transfer active; overrun  out  1  sticky error.
REQ-009 SHALL use parameter WORDS, default 256, words per transfer (line: 4 pixels/word; histo: 2 bins/word, 27 bits each in 32-bit fields).

Function
REQ-010 SHALL detect any change of status_which_line versus its registered copy as a line-done event; completed bank = previous registered value.
REQ-011 SHALL detect status_which_histo changes identically as histo-done events.
REQ-012 SHALL on an event set the kind's pending flag and latch its completed bank.
REQ-013 SHALL start a transfer from IDLE when a pending flag is set, line before histo on simultaneous pending; pending flag clears at start.
REQ-014 SHALL use bus FSM states IDLE, REQ, CAPTURE, GAP.
REQ-015 SHALL in REQ drive vm_bus_enable=vm_rw=1 with vm_address={kind, bank, word}, held stable until the cycle vm_acknowledge=1.
REQ-016 SHALL in the ack cycle load vm_read_data, kind and last flag into the output register, set out_valid, go to CAPTURE.
REQ-017 SHALL deassert vm_bus_enable in CAPTURE and GAP, giving at least one idle cycle between requests (responder is rising-edge sensitive).
REQ-018 SHALL in GAP issue the next REQ only when out_valid=0 or out_ready=1 that cycle; otherwise stay in GAP.
REQ-019 SHALL increment the 8-bit word counter per ack; after word WORDS-1 return to IDLE and clear busy.
REQ-020 SHALL hold out_data/out_kind/out_last stable while out_valid=1 and out_ready=0; a word transfers when both are high.
REQ-021 SHALL set overrun on an event whose kind is already pending or is the active transfer; the active transfer completes, and the newest bank is latched and pending.
REQ-022 SHALL assert busy from transfer start through the ack of the last word.
REQ-023 SHALL never issue a request with vm_address[9:8] differing from the latched kind/bank during a transfer.

Reset
REQ-024 SHALL while rst=0 force IDLE, vm_bus_enable=0, vm_rw=0, vm_address=0, out_valid=0, out_last=0, out_kind=0, out_data=0, busy=0, overrun=0, pending flags 0, word counter 0.
REQ-025 SHALL while rst=0 load the toggle copies from the current status inputs so release produces no spurious event.
REQ-026 SHALL abort an in-flight request on reset with no partial output word.

Structure
REQ-027 SHALL place the bus FSM enum, kind enum, WORDS default and vm_address field positions in shared package vm_pkg.
REQ-028 SHALL implement the single-word handshake (REQ/CAPTURE/GAP) as sub-module vm_read_master; the sequencer, pending and overrun logic stay in vm_fetcher.

Verification
REQ-029 SHALL cover: status_which_line 0->1, out_ready=1 -> 256 words at addresses 0x000..0x0FF, kind 0, out_last only on word 255, overrun=0.
REQ-030 SHALL cover: status_which_histo 1->0 -> addresses 0x300..0x3FF, kind 1, data matches responder model per word.
REQ-031 SHALL cover: both toggles in one cycle -> line transfer fully before histo; 512 words total, no interleaving.
REQ-032 SHALL cover: out_ready=0 for 20 cycles mid-transfer -> vm_bus_enable stays 0, out_data unchanged, no word lost or duplicated.
REQ-033 SHALL cover: second line toggle at word 100 -> overrun=1, transfer finishes at 255, new transfer to bank 0x100 follows.
REQ-034 SHALL cover: rst=0 during REQ -> next cycle enable=0, out_valid=0; after release no request without a new toggle.
